// File: rtl/or1k_marocchino_extadr_ocb_if.sv
// Handshake and destination-register bundle between DECODE/EXECUTE/WRBK
// control and the allocation-ID order-control buffer.
interface or1k_marocchino_extadr_ocb_if #(
    parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
    parameter int unsigned DEST_EXTADR_WIDTH    = 3
);
    // pipeline advance / flush controls
    logic                            padv_exec_i;
    logic                            padv_wrbk_i;
    logic                            pipeline_flush_i;
    // destinations of the instruction in DECODE
    logic                            dcod_rfd1_we_i;
    logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfd1_adr_i;
    logic                            dcod_rfd2_we_i;
    logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfd2_adr_i;
    // ID for DECODE and the oldest in-flight entry
    logic [DEST_EXTADR_WIDTH-1:0]    dcod_extadr_o;
    logic [DEST_EXTADR_WIDTH-1:0]    exec_extadr_o;
    logic                            exec_rfd1_we_o;
    logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd1_adr_o;
    logic                            exec_rfd2_we_o;
    logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd2_adr_o;
    logic                            ocb_empty_o;
    logic                            ocb_full_o;

    // pipeline control side
    modport master (
        output padv_exec_i, padv_wrbk_i, pipeline_flush_i,
        output dcod_rfd1_we_i, dcod_rfd1_adr_i, dcod_rfd2_we_i, dcod_rfd2_adr_i,
        input  dcod_extadr_o, exec_extadr_o,
        input  exec_rfd1_we_o, exec_rfd1_adr_o, exec_rfd2_we_o, exec_rfd2_adr_o,
        input  ocb_empty_o, ocb_full_o
    );

    // order-control buffer side
    modport slave (
        input  padv_exec_i, padv_wrbk_i, pipeline_flush_i,
        input  dcod_rfd1_we_i, dcod_rfd1_adr_i, dcod_rfd2_we_i, dcod_rfd2_adr_i,
        output dcod_extadr_o, exec_extadr_o,
        output exec_rfd1_we_o, exec_rfd1_adr_o, exec_rfd2_we_o, exec_rfd2_adr_o,
        output ocb_empty_o, ocb_full_o
    );
endinterface

// File: rtl/or1k_marocchino_extadr_ocb.sv
// Allocation-ID issuer and in-order retire tracker. Issues a fresh extension
// address to each instruction entering EXECUTE, queues its destinations, and
// presents the oldest in-flight ID/destinations at write-back.
module or1k_marocchino_extadr_ocb #(
    parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
    parameter int unsigned DEST_EXTADR_WIDTH    = 3,
    parameter int unsigned OCB_DEPTH            = 4   // 2 .. 2^DEST_EXTADR_WIDTH-1
) (
    input logic                         cpu_clk,
    input logic                         cpu_rst_n,
    or1k_marocchino_extadr_ocb_if.slave ocb_if
);

    localparam int unsigned PtrW = (OCB_DEPTH > 1) ? $clog2(OCB_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(OCB_DEPTH + 1);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(OCB_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(OCB_DEPTH);

    typedef struct packed {
        logic [DEST_EXTADR_WIDTH-1:0]    extadr;
        logic                            rfd1_we;
        logic [OPTION_RF_ADDR_WIDTH-1:0] rfd1_adr;
        logic                            rfd2_we;
        logic [OPTION_RF_ADDR_WIDTH-1:0] rfd2_adr;
    } entry_t;

    logic [DEST_EXTADR_WIDTH-1:0] extadr_q, extadr_d;
    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]              count_q, count_d;
    entry_t                       mem_q [OCB_DEPTH];

    logic   empty, full;
    logic   push, pop;
    entry_t head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntFull);

    // A simultaneous pop frees the slot, so a push is accepted even when full.
    // Flush overrides both.
    assign push = ocb_if.padv_exec_i & (~full | ocb_if.padv_wrbk_i) & ~ocb_if.pipeline_flush_i;
    assign pop  = ocb_if.padv_wrbk_i & ~empty & ~ocb_if.pipeline_flush_i;

    // Next-state for ID counter, pointers and occupancy
    always_comb begin
        extadr_d = extadr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ocb_if.pipeline_flush_i) begin
            // ID counter keeps running; RAT flags are cleared by the same flush
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                extadr_d = extadr_q + DEST_EXTADR_WIDTH'(1);
                wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            extadr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            extadr_q <= extadr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset keeps the don't-care head outputs free of X
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < int'(OCB_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{extadr:   extadr_q,
                                 rfd1_we:  ocb_if.dcod_rfd1_we_i,
                                 rfd1_adr: ocb_if.dcod_rfd1_adr_i,
                                 rfd2_we:  ocb_if.dcod_rfd2_we_i,
                                 rfd2_adr: ocb_if.dcod_rfd2_adr_i};
        end
    end

    // Head presentation, purely from registered state
    always_comb begin
        head                   = mem_q[rd_ptr_q];
        ocb_if.dcod_extadr_o   = extadr_q;
        ocb_if.exec_extadr_o   = head.extadr;
        ocb_if.exec_rfd1_we_o  = head.rfd1_we & ~empty;
        ocb_if.exec_rfd1_adr_o = head.rfd1_adr;
        ocb_if.exec_rfd2_we_o  = head.rfd2_we & ~empty;
        ocb_if.exec_rfd2_adr_o = head.rfd2_adr;
        ocb_if.ocb_empty_o     = empty;
        ocb_if.ocb_full_o      = full;
    end

endmodule

// File: tb/tb_or1k_marocchino_extadr_ocb.sv
// Directed bench for the allocation-ID order-control buffer (depth 4, 3-bit IDs).
module tb_or1k_marocchino_extadr_ocb;

    logic cpu_clk   = 1'b0;
    logic cpu_rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    or1k_marocchino_extadr_ocb_if #(
        .OPTION_RF_ADDR_WIDTH (5),
        .DEST_EXTADR_WIDTH    (3)
    ) ocb_if ();

    or1k_marocchino_extadr_ocb #(
        .OPTION_RF_ADDR_WIDTH (5),
        .DEST_EXTADR_WIDTH    (3),
        .OCB_DEPTH            (4)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .ocb_if    (ocb_if)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic       exec;
        logic       wrbk;
        logic       flush;
        logic       we1;
        logic [4:0] adr1;
        logic       we2;
        logic [4:0] adr2;
        logic [2:0] dcod;
        logic       chk_head;
        logic [2:0] hext;
        logic [4:0] hadr1;
        logic       hwe1;
        logic       hwe2;
        logic [4:0] hadr2;
        logic       empty;
        logic       full;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic exec, input logic wrbk, input logic flush,
                         input logic we1, input logic [4:0] adr1,
                         input logic we2, input logic [4:0] adr2);
        ocb_if.padv_exec_i      = exec;
        ocb_if.padv_wrbk_i      = wrbk;
        ocb_if.pipeline_flush_i = flush;
        ocb_if.dcod_rfd1_we_i   = we1;
        ocb_if.dcod_rfd1_adr_i  = adr1;
        ocb_if.dcod_rfd2_we_i   = we2;
        ocb_if.dcod_rfd2_adr_i  = adr2;
    endtask

    // One clock edge, then sample 1 time unit later
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        cpu_rst_n = 1'b0;
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            ex wb fl we1 adr1 we2 adr2  dcod chk hext hadr1 hwe1 hwe2 hadr2 emp full
        vecs[0]  = '{1, 0, 0, 1, 5,  0, 0,  1, 1, 0, 5,  1, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 1, 6,  1, 9,  2, 1, 0, 5,  1, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 1, 7,  0, 0,  3, 1, 0, 5,  1, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0,  0, 0,  3, 1, 1, 6,  1, 1, 9, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0,  0, 0,  3, 1, 2, 7,  1, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 0,  0, 0,  3, 0, 0, 0,  0, 0, 0, 1, 0};
        // fill to full starting at ID 3
        vecs[6]  = '{1, 0, 0, 1, 10, 0, 0,  4, 1, 3, 10, 1, 0, 0, 0, 0};
        vecs[7]  = '{1, 0, 0, 1, 11, 0, 0,  5, 1, 3, 10, 1, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 1, 12, 0, 0,  6, 1, 3, 10, 1, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 1, 13, 0, 0,  7, 1, 3, 10, 1, 0, 0, 0, 1};
        // push while full without pop: ignored, nothing overwritten
        vecs[10] = '{1, 0, 0, 1, 20, 1, 21, 7, 1, 3, 10, 1, 0, 0, 0, 1};
        // push + pop while full: ID wraps 7 -> 0
        vecs[11] = '{1, 1, 0, 1, 14, 0, 0,  0, 1, 4, 11, 1, 0, 0, 0, 1};
        vecs[12] = '{0, 1, 0, 0, 0,  0, 0,  0, 1, 5, 12, 1, 0, 0, 0, 0};
        vecs[13] = '{0, 1, 0, 0, 0,  0, 0,  0, 1, 6, 13, 1, 0, 0, 0, 0};
        vecs[14] = '{0, 1, 0, 0, 0,  0, 0,  0, 1, 7, 14, 1, 0, 0, 0, 0};
        vecs[15] = '{0, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0};
        // pop while empty: ignored
        vecs[16] = '{0, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0};
        // push + pop while empty: push only
        vecs[17] = '{1, 1, 0, 1, 3,  1, 4,  1, 1, 0, 3,  1, 1, 4, 0, 0};
        vecs[18] = '{0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 0, 1, 0};

        // reset state
        do_reset();
        chk("reset_dcod_extadr", int'(ocb_if.dcod_extadr_o), 0);
        chk("reset_empty", int'(ocb_if.ocb_empty_o), 1);
        chk("reset_full", int'(ocb_if.ocb_full_o), 0);
        chk("reset_rfd1_we", int'(ocb_if.exec_rfd1_we_o), 0);
        chk("reset_rfd2_we", int'(ocb_if.exec_rfd2_we_o), 0);

        // table: in-order issue/retire, full/stall, empty corner cases
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].exec, vecs[i].wrbk, vecs[i].flush, vecs[i].we1, vecs[i].adr1,
                  vecs[i].we2, vecs[i].adr2);
            step();
            chk($sformatf("v%0d_dcod_extadr", i), int'(ocb_if.dcod_extadr_o), int'(vecs[i].dcod));
            chk($sformatf("v%0d_empty", i), int'(ocb_if.ocb_empty_o), int'(vecs[i].empty));
            chk($sformatf("v%0d_full", i), int'(ocb_if.ocb_full_o), int'(vecs[i].full));
            chk($sformatf("v%0d_rfd1_we", i), int'(ocb_if.exec_rfd1_we_o), int'(vecs[i].hwe1));
            chk($sformatf("v%0d_rfd2_we", i), int'(ocb_if.exec_rfd2_we_o), int'(vecs[i].hwe2));
            if (vecs[i].chk_head) begin
                chk($sformatf("v%0d_head_extadr", i), int'(ocb_if.exec_extadr_o),
                    int'(vecs[i].hext));
                chk($sformatf("v%0d_head_rfd1_adr", i), int'(ocb_if.exec_rfd1_adr_o),
                    int'(vecs[i].hadr1));
                chk($sformatf("v%0d_head_rfd2_adr", i), int'(ocb_if.exec_rfd2_adr_o),
                    int'(vecs[i].hadr2));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // ID wrap: 10 push/pop pairs from reset, pointers wrap twice meanwhile
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 5'(k + 1), 1'b0, 5'd0);
            step();
            chk($sformatf("wrap%0d_head_extadr", k), int'(ocb_if.exec_extadr_o), k % 8);
            chk($sformatf("wrap%0d_head_adr", k), int'(ocb_if.exec_rfd1_adr_o), k + 1);
            chk($sformatf("wrap%0d_dcod_extadr", k), int'(ocb_if.dcod_extadr_o), (k + 1) % 8);
            drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
            step();
            chk($sformatf("wrap%0d_empty", k), int'(ocb_if.ocb_empty_o), 1);
        end
        chk("wrap_end_dcod_extadr", int'(ocb_if.dcod_extadr_o), 2);

        // flush overrides simultaneous push and pop, ID counter kept
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 5'(k + 1), 1'b0, 5'd0);
            step();
        end
        chk("flush_pre_dcod_extadr", int'(ocb_if.dcod_extadr_o), 3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0);
        step();
        chk("flush_empty", int'(ocb_if.ocb_empty_o), 1);
        chk("flush_rfd1_we", int'(ocb_if.exec_rfd1_we_o), 0);
        chk("flush_dcod_extadr", int'(ocb_if.dcod_extadr_o), 3);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
        step();
        chk("post_flush_head_extadr", int'(ocb_if.exec_extadr_o), 3);
        chk("post_flush_head_adr", int'(ocb_if.exec_rfd1_adr_o), 8);
        chk("post_flush_dcod_extadr", int'(ocb_if.dcod_extadr_o), 4);
        chk("post_flush_empty", int'(ocb_if.ocb_empty_o), 0);

        // asynchronous reset between edges with two entries in flight
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("pre_async_dcod_extadr", int'(ocb_if.dcod_extadr_o), 5);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        chk("async_rst_empty", int'(ocb_if.ocb_empty_o), 1);
        chk("async_rst_dcod_extadr", int'(ocb_if.dcod_extadr_o), 0);
        chk("async_rst_rfd1_we", int'(ocb_if.exec_rfd1_we_o), 0);
        chk("async_rst_full", int'(ocb_if.ocb_full_o), 0);
        @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
        step();
        chk("after_async_empty", int'(ocb_if.ocb_empty_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or1k_marocchino_extadr_ocb.md
# or1k_marocchino_extadr_ocb

Allocation-ID issuer and in-order retire tracker for the MAROCCHINO register allocation table. Every instruction that advances into EXECUTE gets a fresh extension address (allocation ID) for the RAT cells. The block records the instruction's destination-register information in an order-control FIFO. At write-back it presents the oldest in-flight ID and destinations, so RAT cells holding that ID drop their allocation flags. It sits between DECODE and the RAT array and is the issuing and retiring counterpart of the per-GPR RAT cells.

## Interface
Parameters:
- OPTION_RF_ADDR_WIDTH, 5, GPR address width.
- DEST_EXTADR_WIDTH, 3, allocation-ID width.
- OCB_DEPTH, 4, FIFO entries. Must satisfy 2 ≤ OCB_DEPTH ≤ 2^DEST_EXTADR_WIDTH − 1, which keeps the next ID to be issued distinct from every in-flight ID.

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- padv_exec_i  in  1  push request: the DECODE instruction advances to EXECUTE.
- padv_wrbk_i  in  1  pop request: the oldest instruction completes write-back.
- pipeline_flush_i  in  1  synchronous flush.
- dcod_rfd1_we_i  in  1  decoded instruction writes D1.
- dcod_rfd1_adr_i  in  OPTION_RF_ADDR_WIDTH  D1 GPR address.
- dcod_rfd2_we_i  in  1  decoded instruction writes D2.
- dcod_rfd2_adr_i  in  OPTION_RF_ADDR_WIDTH  D2 GPR address.
- dcod_extadr_o  out  DEST_EXTADR_WIDTH  ID for the instruction currently in DECODE (ID counter value).
- exec_extadr_o  out  DEST_EXTADR_WIDTH  ID of the head (oldest) entry.
- exec_rfd1_we_o  out  1  head D1 write enable, gated by not-empty.
- exec_rfd1_adr_o  out  OPTION_RF_ADDR_WIDTH  head D1 address.
- exec_rfd2_we_o  out  1  head D2 write enable, gated by not-empty.
- exec_rfd2_adr_o  out  OPTION_RF_ADDR_WIDTH  head D2 address.
- ocb_empty_o  out  1  no instruction in flight.
- ocb_full_o  out  1  OCB_DEPTH instructions in flight; DECODE must stall.

## Operation
- State:
  - ID counter (DEST_EXTADR_WIDTH bits).
  - Write and read pointers, each modulo OCB_DEPTH.
  - Occupancy count, 0..OCB_DEPTH.
  - Storage array of {extadr, rfd1_we, rfd1_adr, rfd2_we, rfd2_adr}.
- Accepted push: padv_exec_i & (~ocb_full_o | padv_wrbk_i).
  - Stores {dcod_extadr_o, dcod_rfd1_we_i, dcod_rfd1_adr_i, dcod_rfd2_we_i, dcod_rfd2_adr_i} at the write pointer.
  - Advances the write pointer.
  - Increments the ID counter modulo 2^DEST_EXTADR_WIDTH; wrap 2^W−1 → 0.
- Accepted pop: padv_wrbk_i & ~ocb_empty_o. Advances the read pointer; stored data is not cleared.
- Push and pop together: occupancy unchanged. This is legal when full (pop frees the slot) but not when empty; on empty only the push is accepted.
- Ignored requests:
  - padv_exec_i while full without padv_wrbk_i: no push, ID counter holds.
  - padv_wrbk_i while empty: no pop.
- Pointers wrap from OCB_DEPTH−1 to 0. Non-power-of-two depth must work.
- Head outputs are combinational from the read-pointer slot. When empty:
  - exec_rfd1_we_o = exec_rfd2_we_o = 0.
  - exec_extadr_o and the address outputs are don't-care, but must be stable (no X propagation after reset).
- Flush (pipeline_flush_i = 1):
  - Occupancy → 0; write pointer ← read pointer. Pointer values are otherwise free.
  - Overrides any push or pop in the same cycle.
  - ID counter is not modified; the RAT flags are cleared by the same flush.
- Flags: ocb_empty_o = (occupancy == 0); ocb_full_o = (occupancy == OCB_DEPTH). Both are derived from registered state.

## Timing
- Reset (asynchronous on cpu_rst_n low, released synchronously by the system):
  - ID counter = 0, pointers = 0, occupancy = 0.
  - ocb_empty_o = 1, ocb_full_o = 0, dcod_extadr_o = 0, exec_rfd1_we_o = exec_rfd2_we_o = 0.
  - Storage array reset to 0.
- Reset during activity: all in-flight entries are lost immediately, with no dependence on clock edges.
- Push latency: an entry pushed into an empty FIFO at edge N is presented on exec_* after edge N (one-cycle push-to-head). dcod_extadr_o shows the next ID after edge N.
- Pop latency: the next entry appears on exec_* right after the popping edge.
- exec_extadr_o is valid in the same cycle padv_wrbk_i is asserted, so RAT cells compare against the retiring ID in that cycle.
- No combinational path from padv_exec_i or padv_wrbk_i to any output.

## Test plan
- Reset: hold cpu_rst_n low for 2 cycles, then release → dcod_extadr_o = 0, ocb_empty_o = 1, ocb_full_o = 0, exec_rfd1_we_o = 0.
- In-order issue and retire: push three instructions with rfd1 addresses 5, 6, 7 (rfd1_we = 1) → stored IDs 0, 1, 2; dcod_extadr_o = 3; head {extadr 0, adr 5}. One pop → head {1, 6}. Two more pops → ocb_empty_o = 1, exec_rfd1_we_o = 0.
- Full and stall (OCB_DEPTH = 4): four pushes → ocb_full_o = 1, dcod_extadr_o = 4.
  - padv_exec_i alone → ignored; dcod_extadr_o stays 4, head ID stays 0.
  - padv_exec_i & padv_wrbk_i → still full, head ID 1, dcod_extadr_o = 5.
- ID wrap: 10 alternating single push/pop pairs → ID sequence 0..7, 0, 1; dcod_extadr_o = 2 at the end. Pointer wrap at depth 4 produces no mismatch between head ID and issue order.
- Flush: three entries in flight; assert pipeline_flush_i together with padv_exec_i and padv_wrbk_i → ocb_empty_o = 1 next cycle; dcod_extadr_o unchanged (3); a following push gets ID 3.
- Asynchronous reset mid-operation: two entries in flight; drop cpu_rst_n between clock edges → ocb_empty_o = 1 and dcod_extadr_o = 0 immediately, before the next edge.
